logic_gate_tester: RTL and testbench
====================================

Name: logic_gate_tester

Overview:
- Sequential stimulus generator and response checker for a two-input AND/OR/NOT gate unit.
- Drives inputs A and B to the unit under test and walks through all four input vectors.
- Samples the unit's three outputs after a settle delay and compares them against the ideal truth table.
- Reports busy/done status, pass/fail and an error count; used as the on-board self-test partner for the gate unit.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range ≥ 1.
- NUM_PASSES, 1, number of complete 4-vector sweeps per run; legal range ≥ 1.
- ERR_W, 4, width of the error counter.

Ports:
- iClk  input  1  system clock; all logic on the rising edge.
- iRst  input  1  synchronous, active-high reset.
- iStart  input  1  start request; single-cycle pulse or level.
- iAnd  input  1  unit-under-test AND output.
- iOr  input  1  unit-under-test OR output.
- iNot  input  1  unit-under-test NOT output (NOT of A).
- oA  output  1  stimulus A; registered.
- oB  output  1  stimulus B; registered.
- oBusy  output  1  run in progress.
- oDone  output  1  run finished; results valid.
- oPass  output  1  run finished with zero errors.
- oErrCnt  output  ERR_W  count of failing vectors, saturating.

Behaviour:
- Reset (iRst=1 at an edge):
  - State goes to IDLE.
  - oA, oB, oBusy, oDone, oPass, oErrCnt, the vector register, the pass counter and the settle counter all clear to 0.
  - Reset overrides every other input, including in the middle of a run.
- States:
  - IDLE:
    - All status outputs are 0.
    - iStart=1 clears vec, the settle counter, the pass counter and oErrCnt, then moves to SETTLE.
  - SETTLE:
    - oA=vec[1] and oB=vec[0], both driven from registers.
    - The settle counter increments each cycle.
    - When settle counter == SETTLE_CYCLES-1, move to CHECK.
  - CHECK (exactly one cycle):
    - Expected values: and=oA&oB, or=oA|oB, not=~oA.
    - Any mismatch on the sampled iAnd/iOr/iNot increments oErrCnt by 1. This is one increment per vector, not per bit.
    - oErrCnt saturates at 2^ERR_W-1.
    - If vec==3 and this is the last pass, move to DONE.
    - Otherwise advance vec (3 wraps to 0 and increments the pass counter), clear the settle counter, and return to SETTLE.
  - DONE:
    - oDone=1 and oPass=(oErrCnt==0).
    - oA and oB hold their last vector (1,1).
    - Outputs hold until iStart=1, which behaves as in IDLE (clears everything and starts a new run).
- Status outputs:
  - oBusy=1 in SETTLE and CHECK, 0 otherwise.
  - oPass is 0 whenever oDone is 0.
  - iStart is ignored while oBusy=1.
- Timing:
  - Vector order within each pass: (A,B) = 00, 01, 10, 11.
  - Run length: oBusy is high for exactly NUM_PASSES*4*(SETTLE_CYCLES+1) cycles.
  - oDone rises on the cycle after the final CHECK.
- Input timing:
  - iAnd, iOr and iNot are sampled directly in CHECK; there is no input synchronizer, because the unit under test shares iClk.
- The counters are sized for NUM_PASSES and SETTLE_CYCLES. The vector register and pass counter never overflow inside a run.

Optional Feature:
- Macro: TESTER_FIRST_FAIL_EN.
- Defined:
  - Adds ports oFailVec (output, 2 bits) and oFailBits (output, 3 bits, ordered {not, or, and}), plus oFailValid (output, 1 bit).
  - On the first mismatching CHECK of a run, these latch the failing vector and a per-bit mismatch mask, and oFailValid goes to 1.
  - Later failures do not overwrite them.
  - They are cleared by reset and by a new start.
- Undefined:
  - The ports and registers do not exist.
  - All other behaviour is identical.

Test Plan:
1. Ideal combinational gate model, defaults; pulse iStart → oBusy high 12 cycles; (oA,oB) shows 00,01,10,11, each held 3 cycles; then oDone=1, oPass=1, oErrCnt=0.
2. iAnd stuck at 0 → only vector 11 fails; oErrCnt=1, oPass=0; with the macro defined, oFailVec=3, oFailBits=3'b001, oFailValid=1.
3. iNot wired to A instead of ~A → all 4 vectors fail; oErrCnt=4; with the macro defined, oFailVec=0, oFailBits=3'b100.
4. NUM_PASSES=5 with the iNot fault from scenario 3 → 20 failures; oErrCnt saturates at 15; oBusy high 60 cycles.
5. iStart re-pulsed at cycle 5 of a run → ignored, run length unchanged; iRst asserted while vec=2 → next cycle all outputs are 0 and the state is IDLE; a following iStart gives a clean full run.
6. From DONE with oErrCnt=4, pulse iStart with an ideal model → oDone drops next cycle, oErrCnt clears to 0, and the run ends with oPass=1.

Source files
------------

// File: rtl/logic_gate_tester.sv
// Self-test stimulus/response checker for a two-input AND/OR/NOT gate unit.
// Optional first-failure capture ports are enabled by defining TESTER_FIRST_FAIL_EN.
module logic_gate_tester #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_W         = 4
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic             iAnd,
  input  logic             iOr,
  input  logic             iNot,
  output logic             oA,
  output logic             oB,
  output logic             oBusy,
  output logic             oDone,
  output logic             oPass,
  output logic [ERR_W-1:0] oErrCnt
`ifdef TESTER_FIRST_FAIL_EN
  ,
  output logic [1:0]       oFailVec,
  output logic [2:0]       oFailBits,
  output logic             oFailValid
`endif
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0]    PASS_LAST   = PW'(NUM_PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [PW-1:0]    pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [2:0]       mism;

  // Per-bit mismatch, ordered {not, or, and}; stimulus comes straight from vec_q
  assign mism = {iNot ^ ~vec_q[1],
                 iOr  ^ (vec_q[1] | vec_q[0]),
                 iAnd ^ (vec_q[1] & vec_q[0])};

`ifdef TESTER_FIRST_FAIL_EN
  logic [1:0] fvec_q, fvec_d;
  logic [2:0] fbits_q, fbits_d;
  logic       fvalid_q, fvalid_d;
`endif

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      pass_q   <= '0;
      err_q    <= '0;
`ifdef TESTER_FIRST_FAIL_EN
      fvec_q   <= '0;
      fbits_q  <= '0;
      fvalid_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
`ifdef TESTER_FIRST_FAIL_EN
      fvec_q   <= fvec_d;
      fbits_q  <= fbits_d;
      fvalid_q <= fvalid_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    pass_d   = pass_q;
    err_d    = err_q;
`ifdef TESTER_FIRST_FAIL_EN
    fvec_d   = fvec_q;
    fbits_d  = fbits_q;
    fvalid_d = fvalid_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (iStart) begin
          state_d  = SETTLE;
          vec_d    = '0;
          settle_d = '0;
          pass_d   = '0;
          err_d    = '0;
`ifdef TESTER_FIRST_FAIL_EN
          fvec_d   = '0;
          fbits_d  = '0;
          fvalid_d = 1'b0;
`endif
        end
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = CHECK;
        else                         settle_d = settle_q + 1'b1;
      end
      CHECK: begin
        if ((|mism) && (err_q != ERR_MAX)) err_d = err_q + 1'b1;
`ifdef TESTER_FIRST_FAIL_EN
        if ((|mism) && !fvalid_q) begin
          fvec_d   = vec_q;
          fbits_d  = mism;
          fvalid_d = 1'b1;
        end
`endif
        if ((vec_q == 2'd3) && (pass_q == PASS_LAST)) begin
          state_d = DONE;
        end else begin
          state_d  = SETTLE;
          settle_d = '0;
          vec_d    = vec_q + 2'd1;
          if (vec_q == 2'd3) pass_d = pass_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // vec_q holds (1,1) in DONE, so the last vector stays on the pins
  assign oA      = vec_q[1];
  assign oB      = vec_q[0];
  assign oBusy   = (state_q == SETTLE) || (state_q == CHECK);
  assign oDone   = (state_q == DONE);
  assign oPass   = oDone && (err_q == '0);
  assign oErrCnt = err_q;
`ifdef TESTER_FIRST_FAIL_EN
  assign oFailVec   = fvec_q;
  assign oFailBits  = fbits_q;
  assign oFailValid = fvalid_q;
`endif

endmodule

// File: tb/tb_logic_gate_tester.sv
// Directed bench for logic_gate_tester: gate-unit fault models drive the checker,
// and each scenario task compares status, counters and stimulus sequence.
module tb_logic_gate_tester;

  logic clk = 1'b0;
  logic rst, start, start5;
  int   fault;
  int   checks = 0;
  int   fails  = 0;
  logic [1:0] seq [256];

  logic a, b, busy, done, pass;
  logic [3:0] err;
  logic and_i, or_i, not_i;
  logic a5, b5, busy5, done5, pass5;
  logic [3:0] err5;
  logic and5_i, or5_i, not5_i;
`ifdef TESTER_FIRST_FAIL_EN
  logic [1:0] fvec, fvec5;
  logic [2:0] fbits, fbits5;
  logic       fvalid, fvalid5;
`endif

  always #5 clk = ~clk;

  // Gate-unit models: 0 ideal, 1 AND stuck at 0, 2 NOT wired to A
  assign and_i  = (fault == 1) ? 1'b0 : (a & b);
  assign or_i   = a | b;
  assign not_i  = (fault == 2) ? a : ~a;
  assign and5_i = (fault == 1) ? 1'b0 : (a5 & b5);
  assign or5_i  = a5 | b5;
  assign not5_i = (fault == 2) ? a5 : ~a5;

  logic_gate_tester dut (
    .iClk(clk), .iRst(rst), .iStart(start),
    .iAnd(and_i), .iOr(or_i), .iNot(not_i),
    .oA(a), .oB(b), .oBusy(busy), .oDone(done), .oPass(pass), .oErrCnt(err)
`ifdef TESTER_FIRST_FAIL_EN
    , .oFailVec(fvec), .oFailBits(fbits), .oFailValid(fvalid)
`endif
  );

  logic_gate_tester #(.NUM_PASSES(5)) dut5 (
    .iClk(clk), .iRst(rst), .iStart(start5),
    .iAnd(and5_i), .iOr(or5_i), .iNot(not5_i),
    .oA(a5), .oB(b5), .oBusy(busy5), .oDone(done5), .oPass(pass5), .oErrCnt(err5)
`ifdef TESTER_FIRST_FAIL_EN
    , .oFailVec(fvec5), .oFailBits(fbits5), .oFailValid(fvalid5)
`endif
  );

  // Pulse start, then sample every busy cycle on the falling edge (bounded).
  task automatic run(input bit sel5, input int repulse_at, output int nb);
    @(negedge clk);
    if (sel5) start5 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start5 = 1'b0;
    nb = 0;
    while ((sel5 ? busy5 : busy) && nb < 200) begin
      seq[nb] = sel5 ? {a5, b5} : {a, b};
      nb++;
      if (nb == repulse_at) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; start5 = 1'b0; fault = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a, b, busy, done, pass, err} !== 9'b0) begin
      fails++; $display("FAIL reset: got %b required 0", {a, b, busy, done, pass, err});
    end
    checks++;
    if ({a5, b5, busy5, done5, pass5, err5} !== 9'b0) begin
      fails++; $display("FAIL reset5: got %b required 0", {a5, b5, busy5, done5, pass5, err5});
    end
    rst = 1'b0;
  endtask

  task automatic test_ideal;
    int nb;
    int bad = 0;
    fault = 0;
    run(1'b0, 0, nb);
    checks++;
    if (nb !== 12) begin fails++; $display("FAIL ideal_busy_len: got %0d required 12", nb); end
    for (int i = 0; i < 12 && i < nb; i++) begin
      checks++;
      if (seq[i] !== 2'((i / 3) % 4)) begin
        fails++; $display("FAIL ideal_seq[%0d]: got %b required %b", i, seq[i], 2'((i / 3) % 4));
      end
    end
    checks++;
    if ({done, pass, err} !== 6'b110000) begin
      fails++; $display("FAIL ideal_result: got done=%b pass=%b err=%0d required 1 1 0", done, pass, err);
    end
    checks++;
    if ({a, b} !== 2'b11) begin fails++; $display("FAIL done_hold_ab: got %b required 11", {a, b}); end
    repeat (3) @(negedge clk);
    checks++;
    if ({done, pass, busy} !== 3'b110) begin
      fails++; $display("FAIL done_hold: got %b required 110", {done, pass, busy});
    end
    if (bad != 0) fails++;
  endtask

  task automatic test_and_stuck;
    int nb;
    fault = 1;
    run(1'b0, 0, nb);
    checks++;
    if ({done, pass, err} !== 6'b100001) begin
      fails++; $display("FAIL and_stuck: got done=%b pass=%b err=%0d required 1 0 1", done, pass, err);
    end
`ifdef TESTER_FIRST_FAIL_EN
    checks++;
    if ({fvalid, fvec, fbits} !== 6'b1_11_001) begin
      fails++; $display("FAIL and_stuck_first: got %b required 111001", {fvalid, fvec, fbits});
    end
`endif
  endtask

  task automatic test_not_fault_and_restart;
    int nb;
    fault = 2;
    run(1'b0, 0, nb);
    checks++;
    if ({done, pass, err} !== 6'b100100) begin
      fails++; $display("FAIL not_fault: got done=%b pass=%b err=%0d required 1 0 4", done, pass, err);
    end
`ifdef TESTER_FIRST_FAIL_EN
    checks++;
    if ({fvalid, fvec, fbits} !== 6'b1_00_100) begin
      fails++; $display("FAIL not_fault_first: got %b required 100100", {fvalid, fvec, fbits});
    end
`endif
    // Restart from DONE with an ideal unit
    fault = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({done, busy, err} !== 6'b010000) begin
      fails++; $display("FAIL restart_clear: got done=%b busy=%b err=%0d required 0 1 0", done, busy, err);
    end
`ifdef TESTER_FIRST_FAIL_EN
    checks++;
    if (fvalid !== 1'b0) begin fails++; $display("FAIL restart_fail_clear: got %b required 0", fvalid); end
`endif
    nb = 0;
    while (busy && nb < 200) begin nb++; @(negedge clk); end
    checks++;
    if ({done, pass, err} !== 6'b110000 || nb !== 12) begin
      fails++; $display("FAIL restart_run: got done=%b pass=%b err=%0d len=%0d required 1 1 0 12", done, pass, err, nb);
    end
  endtask

  task automatic test_saturate;
    int nb;
    fault = 2;
    run(1'b1, 0, nb);
    checks++;
    if (nb !== 60) begin fails++; $display("FAIL sat_busy_len: got %0d required 60", nb); end
    checks++;
    if ({done5, pass5, err5} !== 6'b101111) begin
      fails++; $display("FAIL sat_result: got done=%b pass=%b err=%0d required 1 0 15", done5, pass5, err5);
    end
    fault = 0;
  endtask

  task automatic test_ignore_and_reset;
    int nb;
    int w;
    fault = 0;
    run(1'b0, 5, nb);
    checks++;
    if (nb !== 12 || done !== 1'b1) begin
      fails++; $display("FAIL start_ignored: got len=%0d done=%b required 12 1", nb, done);
    end
    // Start again, abort with reset once vector 10 is on the pins
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while ({a, b} !== 2'b10 && w < 50) begin w++; @(negedge clk); end
    checks++;
    if ({a, b} !== 2'b10) begin fails++; $display("FAIL reach_vec2: got %b required 10", {a, b}); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({a, b, busy, done, pass, err} !== 9'b0) begin
      fails++; $display("FAIL midrun_reset: got %b required 0", {a, b, busy, done, pass, err});
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL idle_after_reset: got busy=%b required 0", busy); end
    run(1'b0, 0, nb);
    checks++;
    if (nb !== 12 || {done, pass, err} !== 6'b110000) begin
      fails++; $display("FAIL clean_run: got len=%0d done=%b pass=%b err=%0d required 12 1 1 0", nb, done, pass, err);
    end
  endtask

  initial begin
    test_reset;
    test_ideal;
    test_and_stuck;
    test_not_fault_and_restart;
    test_saturate;
    test_ignore_and_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
